pucch_f1_seq_mod: RTL
=====================

PUCCH_F1_SEQ_MOD -- requirements
Module: pucch_f1_seq_mod

Interface
- REQ-001 Parameter: SCALE, default 23170, Q15 constant 1/sqrt(2) applied to every product.
- REQ-002 Port: i_clk  input  1  sole clock; all state changes on rising edge.
- REQ-003 Port: i_rst_n  input  1  reset, synchronous, active-low.
- REQ-004 Port: i_valid  input  1  upstream BPSK symbol d(0) valid.
- REQ-005 Port: o_ready  output  1  block can accept a symbol.
- REQ-006 Port: i_re  input  16  d(0) real part, sfix16 Q1.15.
- REQ-007 Port: i_im  input  16  d(0) imaginary part, sfix16 Q1.15.
- REQ-008 Port: i_phi  input  24  12 two-bit phase codes; bits [2n+1:2n] give phi(n): 00=-3, 01=-1, 10=+1, 11=+3.
- REQ-009 Port: o_valid  output  1  output sample valid.
- REQ-010 Port: i_ready  input  1  downstream accepts sample.
- REQ-011 Port: o_re / o_im  output  16 each  y(n) real and imaginary parts, sfix16 Q1.15.
- REQ-012 Port: o_idx  output  4  subcarrier index n of the current sample, 0..11.
- REQ-013 Port: o_last  output  1  high with the n=11 sample.

Function
- REQ-014 Block SHALL compute y(n) = d(0)*r(n), n=0..11, with r(n)=exp(j*pi*phi(n)/4).
- REQ-015 Sign pair (s1,s2) SHALL be: phi=+1 -> (+1,+1); +3 -> (-1,+1); -1 -> (+1,-1); -3 -> (-1,-1).
- REQ-016 Arithmetic: re_sum = a*s1 - b*s2 and im_sum = a*s2 + b*s1, 17-bit signed (a=i_re, b=i_im as latched).
- REQ-017 Scaling: each sum SHALL be multiplied by SCALE, then 16384 added, then arithmetic shift right by 15 (round half up).
- REQ-018 Saturation: scaled result SHALL saturate to [-32768, 32767].
- REQ-019 FSM: two states, IDLE and RUN; o_ready=1 only in IDLE with i_rst_n high.
- REQ-020 IDLE: on i_valid&o_ready, latch i_re, i_im, i_phi; load n=0; go to RUN.
- REQ-021 Latency: o_valid SHALL rise on the cycle after the accepting edge, carrying n=0.
- REQ-022 RUN: while o_valid&~i_ready, o_re, o_im, o_idx and o_last SHALL hold stable.
- REQ-023 RUN: on o_valid&i_ready with n<11, present n+1 on the next cycle; no bubbles.
- REQ-024 RUN: on o_valid&i_ready with n=11 (o_last=1), drop o_valid next cycle and return to IDLE.
- REQ-025 New i_valid during RUN SHALL be ignored; upstream holds, since o_ready=0.
- REQ-026 Input changes after acceptance SHALL NOT affect the sequence in progress.
- REQ-027 Exactly 12 output handshakes per accepted symbol; o_idx SHALL never exceed 11.

Reset
- REQ-028 While i_rst_n=0 at a clock edge: state=IDLE, o_valid=0, o_ready=0, o_re=0, o_im=0, o_idx=0, o_last=0, latched d/phi=0.
- REQ-029 Reset asserted mid-sequence SHALL abort immediately; no further samples of that symbol are emitted.
- REQ-030 First cycle after i_rst_n returns high: o_ready=1.

Verification
- REQ-031 Accept d=(-23170,-23170), all phi=10, i_ready=1 -> 12 consecutive samples (0,-32767), idx 0..11, o_last only at idx 11, o_valid high on the cycle after accept.
- REQ-032 d=(23170,23170), all phi=00 -> every y=(0,-32767); phi=11 -> every y=(-32767,0).
- REQ-033 d=(32767,32767), phi=10 -> y=(0,32767), saturated; d=(-32768,-32768) -> y=(0,-32768), saturated.
- REQ-034 Mixed phi, with random i_ready deassertion -> outputs held stable while stalled; 12 handshakes total; o_ready=0 throughout RUN; a second i_valid is accepted only after the idx-11 handshake.
- REQ-035 i_rst_n low at idx 5 -> next cycle o_valid=0 and all outputs 0; after release o_ready=1 and a new symbol restarts at idx 0.
- REQ-036 i_re/i_im/i_phi toggled after accept -> output sequence matches the latched values only.

Source files
------------

// File: rtl/pucch_f1_seq_mod.sv
// PUCCH format 1 sequence modulator: multiplies one BPSK symbol d(0) by the
// twelve QPSK-phase base sequence values r(n) and streams y(n) with handshake.
module pucch_f1_seq_mod #(
    parameter int SCALE  = 23170,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_re,
    input  logic [DATA_W-1:0] i_im,
    input  logic [23:0]       i_phi,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_re,
    output logic [DATA_W-1:0] o_im,
    output logic [3:0]        o_idx,
    output logic              o_last
);

    localparam int SW   = DATA_W + 2;
    localparam int CW   = COEF_W + 1;
    localparam int PW   = SW + CW + 1;
    localparam int FRAC = 15;

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    localparam logic signed [CW-1:0] SCALE_S = CW'(SCALE);
    localparam logic signed [PW-1:0] ONE     = PW'(1);
    localparam logic signed [PW-1:0] RND     = ONE <<< (FRAC - 1);
    localparam logic signed [PW-1:0] MAX_V   = (ONE <<< (DATA_W - 1)) - ONE;
    localparam logic signed [PW-1:0] MIN_V   = -(ONE <<< (DATA_W - 1));

    logic                     state;
    logic [3:0]               n;
    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;
    logic [23:0]              phi_p0;
    logic                     vld_p0;

    logic [1:0]               code;
    logic                     s1_pos;
    logic                     s2_pos;
    logic signed [SW-1:0]     a_ext;
    logic signed [SW-1:0]     b_ext;
    logic signed [SW-1:0]     re_sum;
    logic signed [SW-1:0]     im_sum;

    // Multiply by the 1/sqrt(2) constant, round half up, clamp to the output range.
    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [SW-1:0] sum);
        logic signed [PW-1:0] s_w;
        logic signed [PW-1:0] k_w;
        logic signed [PW-1:0] prod;
        s_w  = {{(PW - SW){sum[SW-1]}}, sum};
        k_w  = {{(PW - CW){SCALE_S[CW-1]}}, SCALE_S};
        prod = s_w * k_w;
        prod = (prod + RND) >>> FRAC;
        if (prod > MAX_V) begin
            return MAX_V[DATA_W-1:0];
        end else if (prod < MIN_V) begin
            return MIN_V[DATA_W-1:0];
        end
        return prod[DATA_W-1:0];
    endfunction

    // Stage p0: latched symbol and phase codes, walked by subcarrier index n
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            n      <= 4'd0;
            a_p0   <= '0;
            b_p0   <= '0;
            phi_p0 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_p0   <= i_re;
                        b_p0   <= i_im;
                        phi_p0 <= i_phi;
                        n      <= 4'd0;
                        state  <= RUN;
                    end
                end
                default: begin
                    if (i_ready) begin
                        if (n == 4'd11) begin
                            n     <= 4'd0;
                            state <= IDLE;
                        end else begin
                            n <= n + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign vld_p0 = (state == RUN);

    // Stage p0 -> outputs: rotation by +/-1 sign pair, then scale/round/saturate
    always_comb begin
        code   = phi_p0[{n, 1'b0} +: 2];
        // 00=-3 and 11=+3 flip the real sign; only the negative codes flip the imaginary sign
        s1_pos = code[1] ^ code[0];
        s2_pos = code[1];
        a_ext  = {{2{a_p0[DATA_W-1]}}, a_p0};
        b_ext  = {{2{b_p0[DATA_W-1]}}, b_p0};
        re_sum = (s1_pos ? a_ext : -a_ext) - (s2_pos ? b_ext : -b_ext);
        im_sum = (s2_pos ? a_ext : -a_ext) + (s1_pos ? b_ext : -b_ext);
    end

    assign o_ready = (state == IDLE) && i_rst_n;
    assign o_valid = vld_p0;
    assign o_re    = round_sat(re_sum);
    assign o_im    = round_sat(im_sum);
    assign o_idx   = n;
    assign o_last  = vld_p0 && (n == 4'd11);

endmodule
